uart_tx_serializer: RTL

UART transmit engine that drains the 8-deep TX FIFO held in the UART register block and shifts each byte onto the serial line as 8N1 (optionally 8E1) frames. It sits directly downstream of the register block: it consumes `UART_tx_en`, `UART_tx_fifo_empty`, `UART_tx_data` and `UART_baudrate_div`, and it returns the FIFO read strobe `tx_fifo_rd_en`. Its output `uart_txd` drives the pad.

---
 rtl/uart_tx_serializer_if.sv | 21 ++
 rtl/uart_tx_serializer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer_if.sv
// Signal bundle between the UART register block (master) and the TX serializer (slave).
interface uart_tx_serializer_if;
    logic        UART_tx_en;
    logic        UART_tx_fifo_empty;
    logic [7:0]  UART_tx_data;
    logic [31:0] UART_baudrate_div;
    logic        tx_fifo_rd_en;
    logic        uart_txd;
    logic        tx_busy;
    logic        tx_done;

    modport master (
        output UART_tx_en, UART_tx_fifo_empty, UART_tx_data, UART_baudrate_div,
        input  tx_fifo_rd_en, uart_txd, tx_busy, tx_done
    );

    modport slave (
        input  UART_tx_en, UART_tx_fifo_empty, UART_tx_data, UART_baudrate_div,
        output tx_fifo_rd_en, uart_txd, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter: pops the TX FIFO once per frame and shifts out 8N1 frames, or 8E1 frames
// when UART_TX_PARITY_EN is defined.
module uart_tx_serializer (
    input logic                 clk,
    input logic                 rst_n,
    uart_tx_serializer_if.slave tx_if
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StLoad, StStart, StData, StParity, StStop
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [31:0] period_q, period_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        txd_q, txd_d;
    logic        done_q, done_d;
    logic        bit_end;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    assign bit_end = (cnt_q == 32'd0);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (tx_if.UART_tx_en && !tx_if.UART_tx_fifo_empty) state_d = StFetch;
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                shift_d  = tx_if.UART_tx_data;
                period_d = (tx_if.UART_baudrate_div < 32'd2) ? 32'd2 : tx_if.UART_baudrate_div;
                cnt_d    = period_d - 32'd1;
                idx_d    = 3'd0;
`ifdef UART_TX_PARITY_EN
                parity_d = 1'b0;
`endif
                state_d  = StStart;
            end
            StStart: begin
                cnt_d = bit_end ? period_q - 32'd1 : cnt_q - 32'd1;
                if (bit_end) state_d = StData;
            end
            StData: begin
                cnt_d = bit_end ? period_q - 32'd1 : cnt_q - 32'd1;
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    parity_d = parity_q ^ shift_q[0];
                    if (idx_q == 3'd7) state_d = StParity;
`else
                    if (idx_q == 3'd7) state_d = StStop;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                cnt_d = bit_end ? period_q - 32'd1 : cnt_q - 32'd1;
                if (bit_end) state_d = StStop;
            end
`endif
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // txd is registered against the next state so the line changes with the state.
        case (state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: txd_d = parity_d;
`endif
            default: txd_d = 1'b1;
        endcase

        done_d = (state_d == StStop) && (cnt_d == 32'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shift_q  <= 8'd0;
            period_q <= 32'd0;
            cnt_q    <= 32'd0;
            idx_q    <= 3'd0;
            txd_q    <= 1'b1;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            txd_q    <= txd_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx_if.tx_fifo_rd_en = (state_q == StFetch);
    assign tx_if.tx_busy       = (state_q != StIdle);
    assign tx_if.uart_txd      = txd_q;
    assign tx_if.tx_done       = done_q;

endmodule
